// File: rtl/btb_predictor.sv
// Direct-mapped branch target buffer with 2-bit direction counters and a sequential invalidate sweep.
// Optional statistics counters are built only when BTB_STATS_EN is defined.
module btb_predictor #(
  parameter int         ENTRIES  = 16,
  parameter logic [1:0] CTR_INIT = 2'b10,
  localparam int        IDX_W    = $clog2(ENTRIES),
  localparam int        TAG_W    = 30 - IDX_W
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] IF_PC,
  output logic        Pred_Taken,
  output logic [31:0] Pred_Target,
  input  logic        Upd_Valid,
  input  logic [31:0] Upd_PC,
  input  logic        Upd_Taken,
  input  logic [31:0] Upd_Target,
  input  logic        Upd_Pred,
  input  logic        Inv_Req,
  output logic        Busy,
  output logic [31:0] Stat_Updates,
  output logic [31:0] Stat_Mispred
);

  typedef enum logic {IDLE, SWEEP} state_t;

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == 2'b11) ? c : c + 2'd1;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == 2'b00) ? c : c - 2'd1;
  endfunction

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic               valid_q  [ENTRIES];
  logic               valid_d  [ENTRIES];
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [TAG_W-1:0]   tag_d    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];
  logic [31:0]        target_d [ENTRIES];
  logic [1:0]         ctr_q    [ENTRIES];
  logic [1:0]         ctr_d    [ENTRIES];

  logic [IDX_W-1:0] lk_idx, upd_idx;
  logic [TAG_W-1:0] lk_tag, upd_tag;
  logic             lk_hit, upd_hit, upd_accept;

  assign lk_idx  = IF_PC[IDX_W+1:2];
  assign lk_tag  = IF_PC[31:IDX_W+2];
  assign upd_idx = Upd_PC[IDX_W+1:2];
  assign upd_tag = Upd_PC[31:IDX_W+2];

  // Lookups are suppressed while sweeping so stale entries never predict.
  assign lk_hit      = (state_q == IDLE) && valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign Pred_Taken  = lk_hit && ctr_q[lk_idx][1];
  assign Pred_Target = lk_hit ? target_q[lk_idx] : 32'd0;
  assign Busy        = (state_q == SWEEP);

  assign upd_hit    = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
  assign upd_accept = (state_q == IDLE) && Upd_Valid && !Inv_Req;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    case (state_q)
      IDLE: begin
        if (Inv_Req) begin
          state_d = SWEEP;
          ptr_d   = '0;
        end else if (Upd_Valid) begin
          if (upd_hit) begin
            if (Upd_Taken) begin
              ctr_d[upd_idx]    = sat_inc(ctr_q[upd_idx]);
              target_d[upd_idx] = Upd_Target;
            end else begin
              ctr_d[upd_idx]    = sat_dec(ctr_q[upd_idx]);
            end
          end else if (Upd_Taken) begin
            valid_d[upd_idx]  = 1'b1;
            tag_d[upd_idx]    = upd_tag;
            target_d[upd_idx] = Upd_Target;
            ctr_d[upd_idx]    = CTR_INIT;
          end
        end
      end
      SWEEP: begin
        valid_d[ptr_q] = 1'b0;
        if (ptr_q == IDX_W'(ENTRIES - 1)) begin
          state_d = IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d   = ptr_q + IDX_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      target_q <= target_d;
      ctr_q    <= ctr_d;
    end
  end

`ifdef BTB_STATS_EN
  logic [31:0] stat_upd_q, stat_upd_d, stat_mis_q, stat_mis_d;

  always_comb begin
    stat_upd_d = stat_upd_q;
    stat_mis_d = stat_mis_q;
    if (upd_accept) begin
      if (stat_upd_q != 32'hFFFF_FFFF) stat_upd_d = stat_upd_q + 32'd1;
      if ((Upd_Pred != Upd_Taken) && (stat_mis_q != 32'hFFFF_FFFF))
        stat_mis_d = stat_mis_q + 32'd1;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      stat_upd_q <= '0;
      stat_mis_q <= '0;
    end else begin
      stat_upd_q <= stat_upd_d;
      stat_mis_q <= stat_mis_d;
    end
  end

  assign Stat_Updates = stat_upd_q;
  assign Stat_Mispred = stat_mis_q;

  logic unused_bits;
  assign unused_bits = ^{IF_PC[1:0], Upd_PC[1:0]};
`else
  assign Stat_Updates = 32'd0;
  assign Stat_Mispred = 32'd0;

  logic unused_bits;
  assign unused_bits = ^{IF_PC[1:0], Upd_PC[1:0], Upd_Pred, upd_accept};
`endif

endmodule

// File: doc/btb_predictor.md
# btb_predictor

Parametrised direct-mapped branch target buffer with 2-bit saturating direction counters, for the IF stage of the MIPS pipeline. Looks up the current PC combinationally and supplies a predicted-taken flag and target to the next-PC mux. Learns from branches resolved in ID. Has a sequential sweep engine that invalidates the whole table on request.

## Interface
- ENTRIES, 16: number of table entries; power of two, 2..1024.
- IDX_W, log2(ENTRIES): index width; derived, never overridden.
- TAG_W, 30-IDX_W: tag width; derived.
- CTR_INIT, 2'b10: counter value written on allocation (weakly taken).
- CLK  in  1  clock; all state changes on the rising edge.
- RESET  in  1  asynchronous, active-low reset.
- IF_PC  in  32  PC being fetched.
- Pred_Taken  out  1  lookup hit and counter MSB set.
- Pred_Target  out  32  stored target of the hit entry; 0 on miss.
- Upd_Valid  in  1  a branch resolved in ID this cycle.
- Upd_PC  in  32  PC of the resolved branch.
- Upd_Taken  in  1  actual direction.
- Upd_Target  in  32  actual target (ID_PC_4 + offset<<2).
- Upd_Pred  in  1  prediction originally made for this branch, carried through IF/ID.
- Inv_Req  in  1  single-cycle request to invalidate all entries.
- Busy  out  1  sweep in progress.
- Stat_Updates  out  32  count of accepted updates (see Configuration).
- Stat_Mispred  out  32  count of mispredictions (see Configuration).

## Operation
- Index = PC[IDX_W+1:2]. Tag = PC[31:IDX_W+2]. PC[1:0] is ignored.
- Each entry holds valid, tag, target[31:0] and ctr[1:0].
- **Lookup (combinational):**
  - hit = valid[idx] && tag match && state==IDLE.
  - Pred_Taken = hit && ctr[1].
  - Pred_Target = hit ? target : 0.
- **Update** (when Upd_Valid, state==IDLE):
  - On a hit, taken: ctr saturating-increments (max 3) and target is overwritten.
  - On a hit, not taken: ctr saturating-decrements (min 0) and target is kept.
  - On a miss, taken: allocate the entry. Set valid=1, write tag and target, set ctr=CTR_INIT. This replaces any conflicting entry.
  - On a miss, not taken: no change.
- **FSM states:** IDLE and SWEEP.
  - IDLE -> SWEEP when Inv_Req is high. The sweep pointer loads 0.
  - In SWEEP, each cycle clears valid[ptr], then ptr increments.
  - When ptr==ENTRIES-1 is cleared, the FSM returns to IDLE.
  - Busy is high exactly in SWEEP.
- **During SWEEP:**
  - Upd_Valid is ignored.
  - Inv_Req is ignored.
  - Lookups miss.
- If Inv_Req and Upd_Valid are high in the same IDLE cycle, the invalidate wins and the update is dropped.

## Timing
- Lookup latency is 0 cycles; outputs are combinational from IF_PC and the table.
- Updates are written at the rising edge of the Upd_Valid cycle.
- A lookup of the same index in that cycle sees the pre-update contents; there is no bypass.
- A sweep takes exactly ENTRIES cycles. Busy goes high the cycle after Inv_Req and stays high for ENTRIES cycles.
- **Reset (RESET=0), asynchronous:**
  - All valid bits are cleared and all ctr are set to 2'b01.
  - Tags and targets are set to 0.
  - The FSM goes to IDLE and ptr to 0.
  - Busy=0, Pred_Taken=0, Pred_Target=0, and both Stat counters are 0.
- Reset asserted mid-sweep aborts it immediately. The table is fully invalid after reset regardless of progress.
- Deassertion is taken at the next rising edge of CLK.

## Configuration
- Macro BTB_STATS_EN controls the statistics counters.
- **Defined:**
  - Stat_Updates increments on every accepted update (Upd_Valid in IDLE).
  - Stat_Mispred increments on every accepted update where Upd_Pred != Upd_Taken.
  - Both are 32-bit counters that saturate at 32'hFFFF_FFFF.
  - Inv_Req does not clear them; only reset does.
- **Undefined:** the ports remain present and are driven 0, and no counter flops are built.

## Test plan
- **Reset:** assert RESET=0 mid-sweep, release, look up any PC -> Pred_Taken=0, Pred_Target=0, Busy=0.
- **Allocate:** update with Upd_PC=0x0040_0010, Upd_Taken=1, Upd_Target=0x0040_0100.
  - Same-cycle lookup -> miss.
  - Next-cycle lookup of 0x0040_0010 -> Pred_Taken=1, Pred_Target=0x0040_0100.
- **Hysteresis:** after allocation, apply two not-taken updates -> ctr goes 10->01->00 and Pred_Taken=0. One taken update -> ctr=01, still not taken. A second taken update -> ctr=10, taken.
- **Aliasing (ENTRIES=16):** allocate 0x0000_0040, then allocate 0x0000_0440 (same index, different tag).
  - Lookup of 0x0000_0040 -> miss.
  - Lookup of 0x0000_0440 -> hit.
- **Sweep:** fill 4 entries, then pulse Inv_Req together with Upd_Valid.
  - Busy is high for 16 cycles.
  - The update is dropped.
  - Every lookup misses during and after the sweep.
- **Stats (BTB_STATS_EN):** 5 updates, 2 with Upd_Pred != Upd_Taken -> Stat_Updates=5, Stat_Mispred=2. Force Stat_Updates to 0xFFFF_FFFF and update -> it stays at 0xFFFF_FFFF.
